rd_latency0_to_n: RTL and testbench



---
 rtl/rd_latency0_to_n.sv | 61 ++++++
 tb/tb_rd_latency0_to_n.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rd_latency0_to_n.sv
// rd_latency0_to_n: show-ahead buffer read port to fixed LATENCY read port; define RD_LAT_UNDERFLOW_CNT_EN to add underflow_cnt
module rd_latency0_to_n #(
  parameter int WIDTH = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [WIDTH-1:0] in_rd_data,
  input  logic             out_rd_en,
  output logic             out_rd_valid,
  output logic [WIDTH-1:0] out_rd_data,
  input  logic             flush,
  output logic             out_underflow,
  output logic             underflow_sticky,
  input  logic             clear_stat
`ifdef RD_LAT_UNDERFLOW_CNT_EN
  , output logic [15:0]    underflow_cnt
`endif
);
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("rd_latency0_to_n: LATENCY must be in 1..4");
  end
  logic [LATENCY-1:0] v, vin;
  logic [WIDTH-1:0] d [LATENCY];
  logic [WIDTH-1:0] din [LATENCY];
  logic uf;
  assign in_rd_en = out_rd_en & ~in_empty & ~flush & ~rst;
  assign uf = out_rd_en & in_empty & ~flush & ~rst;
  assign out_rd_valid = v[LATENCY-1];
  assign out_rd_data = d[LATENCY-1];
  always_comb begin
    vin[0] = in_rd_en;
    din[0] = in_rd_data;
    for (int i = 1; i < LATENCY; i++) begin
      vin[i] = v[i-1];
      din[i] = d[i-1];
    end
  end
  // data registers move only with a live word, so flushed or bubble slots keep their old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
      out_underflow <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      v <= flush ? '0 : vin;
      for (int i = 0; i < LATENCY; i++) if (vin[i] && !flush) d[i] <= din[i];
      out_underflow <= uf;
      underflow_sticky <= uf | (underflow_sticky & ~clear_stat);
    end
  end
`ifdef RD_LAT_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clear_stat) underflow_cnt <= '0;
    else if (uf && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rd_latency0_to_n.sv
// tb_rd_latency0_to_n: checks LATENCY 1/3/4 instances against a show-ahead buffer model and a timed scoreboard
module tb_rd_latency0_to_n;
  typedef struct {logic [31:0] d; int due;} ent_t;
  typedef struct {bit r; bit e; bit f; bit c; int n; bit x;} vec_t;
  logic clk = 0, rst = 1, out_rd_en = 0, flush = 0, clear_stat = 0;
  always #5 clk = ~clk;
  logic [31:0] mem [256];
  logic [7:0] rp = 0, wp = 0;
  logic in_empty;
  logic [31:0] in_rd_data;
  assign in_empty = rp == wp;
  assign in_rd_data = mem[rp];
  logic rd_en [3], vld [3], ufl [3], st [3];
  logic [31:0] dout [3];
`ifdef RD_LAT_UNDERFLOW_CNT_EN
  logic [15:0] cnt [3];
`endif
  for (genvar g = 0; g < 3; g++) begin : dut
    rd_latency0_to_n #(.WIDTH(32), .LATENCY(g == 0 ? 1 : g + 2)) u (
      .clk(clk), .rst(rst), .in_rd_en(rd_en[g]), .in_empty(in_empty),
      .in_rd_data(in_rd_data), .out_rd_en(out_rd_en), .out_rd_valid(vld[g]),
      .out_rd_data(dout[g]), .flush(flush), .out_underflow(ufl[g]),
      .underflow_sticky(st[g]), .clear_stat(clear_stat)
`ifdef RD_LAT_UNDERFLOW_CNT_EN
      , .underflow_cnt(cnt[g])
`endif
    );
  end
  int tests = 0, fails = 0, cyc = 0, seq = 0;
  ent_t q [3][$];
  logic [31:0] last [3];
  logic [31:0] pend [$];
  bit x_uf = 0, x_st = 0;
  logic [15:0] x_cnt = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // reference model: buffer pops and scoreboard pushes at the clock edge
  always @(posedge clk) begin
    bit pop, ev;
    cyc++;
    pop = out_rd_en && !in_empty && !flush && !rst;
    ev = out_rd_en && in_empty && !flush && !rst;
    for (int i = 0; i < 3; i++) begin
      if (rst || flush) q[i].delete();
      else if (pop) q[i].push_back('{in_rd_data, cyc + (i == 0 ? 1 : i + 2) - 1});
      if (rst) last[i] = 0;
    end
    x_uf = ev;
    x_st = !rst && (ev || (x_st && !clear_stat));
    x_cnt = (rst || clear_stat) ? 16'd0 : (ev && x_cnt != 16'hFFFF) ? x_cnt + 16'd1 : x_cnt;
    if (pop) rp <= rp + 8'd1;
  end
  always @(negedge clk) begin
    bit xv;
    for (int i = 0; i < 3; i++) begin
      xv = q[i].size() > 0 && q[i][0].due == cyc;
      chk($sformatf("valid[%0d]", i), vld[i], xv);
      if (xv) last[i] = q[i].pop_front().d;
      chk($sformatf("data[%0d]", i), dout[i], last[i]);
      chk($sformatf("rd_en[%0d]", i), rd_en[i], out_rd_en && !in_empty && !flush && !rst);
      chk($sformatf("underflow[%0d]", i), ufl[i], x_uf);
      chk($sformatf("sticky[%0d]", i), st[i], x_st);
`ifdef RD_LAT_UNDERFLOW_CNT_EN
      chk($sformatf("cnt[%0d]", i), cnt[i], x_cnt);
`endif
    end
  end
  task automatic drive(bit r, bit e, bit f, bit c);
    @(negedge clk);
    #2;
    while (pend.size() > 0) begin
      mem[wp] = pend.pop_front();
      wp = wp + 8'd1;
    end
    rst = r; out_rd_en = e; flush = f; clear_stat = c;
  endtask
  vec_t tbl [20];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tbl = '{
      '{1,1,0,0,1,0}, '{0,1,0,0,0,1}, '{0,1,0,0,0,0}, '{0,1,1,0,2,0},
      '{0,1,0,0,0,1}, '{0,0,0,1,0,0}, '{0,1,0,1,0,1}, '{0,1,0,1,0,0},
      '{0,0,0,0,0,0}, '{0,1,0,0,3,1}, '{0,1,0,0,0,1}, '{0,1,0,0,0,1},
      '{0,0,1,0,0,0}, '{0,0,0,0,0,0}, '{0,1,0,0,2,1}, '{0,1,0,0,0,1},
      '{1,1,0,0,1,0}, '{0,0,0,0,0,0}, '{0,1,0,0,0,1}, '{0,0,0,0,0,0}};
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin pend.push_back(32'hC0DE_0000 + seq); seq++; end
      drive(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].c);
      #1 chk($sformatf("tbl_rd_en[%0d]", i), rd_en[0], tbl[i].x);
    end
    repeat (6) drive(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) pend.push_back(32'hA5A5_0000 + k);
    repeat (4) drive(0, 1, 0, 0);
    repeat (6) drive(0, 0, 0, 0);
    pend.push_back(32'h0000_BEEF);
    drive(0, 1, 0, 0);
    repeat (8) drive(0, 0, 0, 0);
    #1 chk("beef_hold", dout[1], 32'h0000_BEEF);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    #1 chk("uf_sticky", st[2], 1'b1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    #1 chk("sticky_clr", st[2], 1'b0);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(9) < 4) begin pend.push_back($urandom); end
      drive(0, $urandom_range(9) < 7, $urandom_range(19) == 0, $urandom_range(19) == 0);
    end
    repeat (6) drive(0, 0, 0, 0);
`ifdef RD_LAT_UNDERFLOW_CNT_EN
    repeat (65540) drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    #1 chk("cnt_sat", cnt[0], 16'hFFFF);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    #1 chk("cnt_clr", cnt[0], 16'h0000);
`endif
    repeat (3) drive(0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
